// File: rtl/axi4_lite_input_loader.sv
// AXI4-Lite slave that accepts input-layer words from the host, buffers them in
// a FIFO and streams them to layer 0 over an AXI-Stream master.
//
// Handshake semantics (all channels): a transfer happens on the rising edge where
// valid and ready are both high. The slave never drops a valid it has raised
// (bvalid, rvalid, m_tvalid) until the matching ready is seen, and its payload
// (bresp, rdata, m_tdata/m_tlast) is stable while valid is high and ready is low.
// awready/wready and arready are single-cycle pulses.
module axi4_lite_input_loader #(
    parameter int N_WORDS    = 784,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  s_axil_awaddr,
    input  logic [2:0]  s_axil_awprot,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    input  logic [3:0]  s_axil_araddr,
    input  logic [2:0]  s_axil_arprot,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        frame_done
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LAST_IDX = 16'(N_WORDS - 1);
    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

    logic [31:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, fifo_level;
    logic        fifo_empty, fifo_full;
    logic        enable, offered;
    logic [15:0] beat_cnt;
    logic        wr_hs, rd_hs, is_ctrl, ctrl_clear, ctrl_w1c, data_wr, push_ok;
    logic        beat, last_beat;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fifo_level == DEPTH_L);

    // Write decode: address and data are always taken together in one pulse.
    assign wr_hs      = s_axil_awready & s_axil_awvalid & s_axil_wvalid;
    assign is_ctrl    = wr_hs & (s_axil_awaddr[3:2] == 2'd0) & s_axil_wstrb[0];
    assign ctrl_clear = is_ctrl & s_axil_wdata[1];
    assign ctrl_w1c   = is_ctrl & s_axil_wdata[2];
    assign data_wr    = wr_hs & (s_axil_awaddr[3:2] == 2'd2);
    // A full FIFO refuses the push even if a pop happens on the same edge.
    assign push_ok    = data_wr & (s_axil_wstrb == 4'hF) & ~fifo_full;

    // Once a beat is offered it stays offered until taken, even if enable drops.
    assign m_tvalid  = ~fifo_empty & (enable | offered);
    assign m_tdata   = fifo_empty ? 32'd0 : fifo_mem[rd_ptr[AW-1:0]];
    assign m_tlast   = m_tvalid & (beat_cnt == LAST_IDX);
    assign beat      = m_tvalid & m_tready;
    assign last_beat = beat & (beat_cnt == LAST_IDX);

    assign s_axil_wready = s_axil_awready;
    assign s_axil_rresp  = 2'b00;

    // Write address/data pulse and write response channel.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axil_awready <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= 2'b00;
        end else begin
            s_axil_awready <= s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid & ~s_axil_awready;
            if (wr_hs) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= (data_wr & ~push_ok) ? 2'b10 : 2'b00;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    // CTRL enable bit and sticky frame_done (a same-edge set beats the W1C).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            enable     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (is_ctrl) enable <= s_axil_wdata[0];
            if (last_beat)     frame_done <= 1'b1;
            else if (ctrl_w1c) frame_done <= 1'b0;
        end
    end

    // Read data mux for the register map; unmapped and write-only words read 0.
    always_comb begin
        rd_mux = 32'd0;
        case (s_axil_araddr[3:2])
            2'd0:    rd_mux = {29'd0, frame_done, 1'b0, enable};
            2'd1:    rd_mux = {beat_cnt, 12'd0, frame_done, fifo_full, fifo_empty, enable};
            default: rd_mux = 32'd0;
        endcase
    end

    // Read address pulse and read data channel.
    assign rd_hs = s_axil_arready & s_axil_arvalid;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= 32'd0;
        end else begin
            s_axil_arready <= s_axil_arvalid & ~s_axil_arready & ~s_axil_rvalid;
            if (rd_hs) begin
                s_axil_rdata  <= rd_mux;
                s_axil_rvalid <= 1'b1;
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

    // FIFO pointers, beat counter and offer-hold flag; clear overrides push/pop.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= 16'd0;
            offered  <= 1'b0;
        end else if (ctrl_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= 16'd0;
            offered  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (beat) begin
                rd_ptr   <= rd_ptr + 1'b1;
                beat_cnt <= last_beat ? 16'd0 : beat_cnt + 16'd1;
            end
            offered <= m_tvalid & ~m_tready;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge aclk) begin
        if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= s_axil_wdata;
    end
endmodule

// File: tb/tb_axi4_lite_input_loader.sv
module tb_axi4_lite_input_loader;
  localparam int N_WORDS    = 4;
  localparam int FIFO_DEPTH = 16;
  localparam logic [3:0] A_CTRL = 4'h0, A_STAT = 4'h4, A_DATA = 4'h8, A_RSVD = 4'hC;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  s_axil_awaddr = '0;
  logic [2:0]  s_axil_awprot = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [3:0]  s_axil_araddr = '0;
  logic [2:0]  s_axil_arprot = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int mcnt = 0;

  typedef struct {
    bit          is_rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[10];

  axi4_lite_input_loader #(.N_WORDS(N_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .frame_done(frame_done)
  );

  // clock
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // driver tasks: entered and left just after a rising edge
  task automatic axil_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
    int n;
    s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    n = 0;
    while (!s_axil_awready && n < 20) begin @(posedge aclk); #1; n++; end
    if (!s_axil_awready) timeout_fail("awready_wait");
    @(posedge aclk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n = 0;
    while (!s_axil_bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!s_axil_bvalid) timeout_fail("bvalid_wait");
    resp = s_axil_bresp;
    s_axil_bready = 1'b1;
    @(posedge aclk); #1;
    s_axil_bready = 1'b0;
  endtask

  task automatic axil_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    n = 0;
    while (!s_axil_arready && n < 20) begin @(posedge aclk); #1; n++; end
    if (!s_axil_arready) timeout_fail("arready_wait");
    @(posedge aclk); #1;
    s_axil_arvalid = 1'b0;
    n = 0;
    while (!s_axil_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!s_axil_rvalid) timeout_fail("rvalid_wait");
    data = s_axil_rdata; resp = s_axil_rresp;
    s_axil_rready = 1'b1;
    @(posedge aclk); #1;
    s_axil_rready = 1'b0;
  endtask

  task automatic wr_chk(input string name, input logic [3:0] addr, input logic [31:0] data,
                        input logic [1:0] exp_resp);
    logic [1:0] resp;
    axil_write(addr, data, 4'hF, resp);
    check(name, 32'(resp), 32'(exp_resp));
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  resp;
    axil_read(addr, d, resp);
    check(name, d, exp);
    check({name, "_rresp"}, 32'(resp), 32'd0);
  endtask

  // expected word is queued before the write, since the beat can land before bvalid clears
  task automatic push_word(input logic [31:0] d, input bit exp_ok);
    logic [1:0] resp;
    if (exp_ok) exp_q.push_back(d);
    axil_write(A_DATA, d, 4'hF, resp);
    check("data_bresp", 32'(resp), exp_ok ? 32'd0 : 32'd2);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge aclk); #1; n++; end
    repeat (2) @(posedge aclk);
    #1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // vector table: register-level behaviour from a clean reset
    vecs[0] = '{1'b0, A_CTRL, 32'h1,          4'hF, 2'b00, 32'h0};
    vecs[1] = '{1'b1, A_CTRL, 32'h0,          4'h0, 2'b00, 32'h1};
    vecs[2] = '{1'b0, A_DATA, 32'hAA,         4'h3, 2'b10, 32'h0};
    vecs[3] = '{1'b1, A_STAT, 32'h0,          4'h0, 2'b00, 32'h3};
    vecs[4] = '{1'b1, A_RSVD, 32'h0,          4'h0, 2'b00, 32'h0};
    vecs[5] = '{1'b1, A_DATA, 32'h0,          4'h0, 2'b00, 32'h0};
    vecs[6] = '{1'b0, A_RSVD, 32'hFFFF_FFFF,  4'hF, 2'b00, 32'h0};
    vecs[7] = '{1'b1, A_CTRL, 32'h0,          4'h0, 2'b00, 32'h1};
    vecs[8] = '{1'b0, A_CTRL, 32'h0,          4'hF, 2'b00, 32'h0};
    vecs[9] = '{1'b1, A_STAT, 32'h0,          4'h0, 2'b00, 32'h2};

    // stream monitor / scoreboard
    fork
      forever begin
        logic [31:0] exp_w;
        @(negedge aclk);
        if (aresetn && m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected: got beat %h expected none", m_tdata);
          end else begin
            exp_w = exp_q.pop_front();
            check("beat_data", m_tdata, exp_w);
            check("beat_last", 32'(m_tlast), (mcnt == N_WORDS - 1) ? 32'd1 : 32'd0);
            mcnt = (mcnt == N_WORDS - 1) ? 0 : mcnt + 1;
          end
        end
      end
    join_none

    // reset block
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", 32'(s_axil_awready), 32'd0);
    check("rst_bvalid",  32'(s_axil_bvalid),  32'd0);
    check("rst_bresp",   32'(s_axil_bresp),   32'd0);
    check("rst_arready", 32'(s_axil_arready), 32'd0);
    check("rst_rvalid",  32'(s_axil_rvalid),  32'd0);
    check("rst_rdata",   s_axil_rdata,        32'd0);
    check("rst_tvalid",  32'(m_tvalid),       32'd0);
    check("rst_tdata",   m_tdata,             32'd0);
    check("rst_tlast",   32'(m_tlast),        32'd0);
    check("rst_fdone",   32'(frame_done),     32'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // table-driven register accesses
    for (int i = 0; i < 10; i++) begin
      logic [31:0] d;
      logic [1:0]  resp;
      if (vecs[i].is_rd) begin
        axil_read(vecs[i].addr, d, resp);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        axil_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end
    end

    // three words stream out in order, no tlast
    m_tready = 1'b1;
    wr_chk("en_on", A_CTRL, 32'h1, 2'b00);
    for (int i = 1; i <= 3; i++) push_word(32'(i), 1'b1);
    wait_drain();
    rd_chk("stat_3beats", A_STAT, 32'h0003_0003);

    // fourth word completes the frame
    push_word(32'h4, 1'b1);
    wait_drain();
    check("fdone_set", 32'(frame_done), 32'd1);
    rd_chk("stat_frame", A_STAT, 32'h0000_000B);
    wr_chk("w1c", A_CTRL, 32'h5, 2'b00);
    check("fdone_clr", 32'(frame_done), 32'd0);
    rd_chk("stat_w1c", A_STAT, 32'h0000_0003);

    // overflow with streaming disabled
    wr_chk("en_off", A_CTRL, 32'h0, 2'b00);
    for (int i = 0; i <= FIFO_DEPTH; i++) push_word(32'h100 + 32'(i), i < FIFO_DEPTH);
    rd_chk("stat_full", A_STAT, 32'h0000_0004);

    // backpressure: offered beat held stable, then released for one beat
    m_tready = 1'b0;
    wr_chk("en_bp", A_CTRL, 32'h1, 2'b00);
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      check("bp_tvalid", 32'(m_tvalid), 32'd1);
      check("bp_tdata", m_tdata, 32'h100);
    end
    m_tready = 1'b1;
    @(posedge aclk); #1;
    m_tready = 1'b0;
    rd_chk("stat_bp", A_STAT, 32'h0001_0001);
    m_tready = 1'b1;
    wait_drain();
    rd_chk("stat_drain16", A_STAT, 32'h0000_000B);
    wr_chk("w1c2", A_CTRL, 32'h5, 2'b00);

    // enable dropped while a beat is offered: beat stays until taken
    m_tready = 1'b0;
    push_word(32'h200, 1'b1);
    push_word(32'h201, 1'b1);
    wr_chk("en_drop", A_CTRL, 32'h0, 2'b00);
    check("hold_tvalid", 32'(m_tvalid), 32'd1);
    check("hold_tdata", m_tdata, 32'h200);
    m_tready = 1'b1;
    @(posedge aclk); #1;
    m_tready = 1'b0;
    check("stall_tvalid", 32'(m_tvalid), 32'd0);
    rd_chk("stat_stall", A_STAT, 32'h0001_0000);

    // clear flushes FIFO and counter
    exp_q.delete();
    mcnt = 0;
    wr_chk("clear", A_CTRL, 32'h2, 2'b00);
    check("clr_tvalid", 32'(m_tvalid), 32'd0);
    rd_chk("stat_clear", A_STAT, 32'h0000_0002);

    // async reset mid-frame with five words queued
    wr_chk("en_rst", A_CTRL, 32'h1, 2'b00);
    m_tready = 1'b1;
    push_word(32'h300, 1'b1);
    wait_drain();
    m_tready = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(32'h300 + 32'(i), 1'b1);
    check("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_tvalid", 32'(m_tvalid), 32'd0);
    check("arst_tdata", m_tdata, 32'd0);
    check("arst_tlast", 32'(m_tlast), 32'd0);
    check("arst_rdata", s_axil_rdata, 32'd0);
    check("arst_bvalid", 32'(s_axil_bvalid), 32'd0);
    exp_q.delete();
    mcnt = 0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    rd_chk("stat_after_rst", A_STAT, 32'h0000_0002);
    wr_chk("en_post", A_CTRL, 32'h1, 2'b00);
    m_tready = 1'b1;
    push_word(32'h400, 1'b1);
    wait_drain();
    rd_chk("stat_post", A_STAT, 32'h0001_0003);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
